ir_nec_receiver: RTL and testbench
==================================

# ir_nec_receiver

Decodes the demodulated output of the IR receiver module (NEC protocol, 38 kHz carrier already removed) into a 32-bit frame. It sits directly upstream of the IR command controller and supplies the `ir_data` / `data_ready` pair whose byte [23:16] selects STOP/LEFT/RIGHT/FAST/SLOW. It measures pulse widths with a cycle counter, validates leader, bit and stop timing plus the command-complement byte, and flags NEC repeat codes separately.

## Interface
- `CYC_PER_US`, default 50: clock cycles per microsecond (50 MHz). Benches may override to 1 for speed.
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset; synchronous and active-low.
- `ir_in`  in  1  raw receiver output, asynchronous; idle high, carrier burst = low.
- `ir_data`  out  32  last valid frame: [7:0] address, [15:8] address byte 2, [23:16] command, [31:24] ~command.
- `data_ready`  out  1  one-cycle pulse when `ir_data` has just been updated.
- `repeat_code`  out  1  one-cycle pulse on a valid NEC repeat frame.
- `frame_error`  out  1  one-cycle pulse when a frame is aborted.

## Operation
- `ir_in` passes through a 2-flop synchronizer (both flops reset to 1); all decoding uses the synchronized signal `s` and its edge detect.
- Duration counter: counts cycles since the last edge of `s`, cleared on each edge, saturates at all-ones (width ≥ ceil(log2(11000·CYC_PER_US+1))).
- Every duration below is in µs × CYC_PER_US, bounds inclusive; the duration is classified at the edge that ends the interval.
- States:
  - IDLE: on falling edge of `s` -> LEAD_BURST.
  - LEAD_BURST: at rising edge, low 8000–10000 -> LEAD_SPACE; otherwise error.
  - LEAD_SPACE: at falling edge, high 4000–5000 -> BIT_BURST, bit index = 0; high 2000–2500 -> STOP_BURST with repeat flag set; otherwise error.
  - BIT_BURST: at rising edge, low 400–700 -> BIT_SPACE; otherwise error.
  - BIT_SPACE: at falling edge, high 400–700 -> bit 0; high 1400–1900 -> bit 1; otherwise error.
    - The bit is written to `shift[idx]`, so bits arrive LSB first.
    - If idx = 31 -> STOP_BURST; else idx+1 -> BIT_BURST.
  - STOP_BURST: at rising edge, low 400–700 -> completion, then IDLE; otherwise error.
- Timeout: in any non-IDLE state, when the counter reaches 11000 µs without an edge -> error.
- Completion of a data frame:
  - If shift[31:24] == ~shift[23:16]: copy `shift` to `ir_data` and pulse `data_ready`.
  - Otherwise pulse `frame_error`; `ir_data` is unchanged.
  - Address bytes are not checked.
- Completion of a repeat frame: pulse `repeat_code`; `ir_data` is unchanged.
- Error handling:
  - Pulse `frame_error`, clear the repeat flag, go to IDLE.
  - If `s` is currently low, go to LEAD_BURST instead, so the offending falling edge can start a new frame.
- The shift register is internal; `ir_data` only ever holds complement-valid frames.

## Timing
- Reset (rst_n low at a clk edge):
  - State IDLE; counter, index, shift and repeat flag cleared.
  - `ir_data` = 0; `data_ready`, `repeat_code`, `frame_error` = 0.
  - Synchronizer flops = 1.
  - Reset mid-frame discards the partial frame with no error pulse.
- Synchronizer latency: 2 cycles from `ir_in` to `s`.
- Completion: `data_ready` / `repeat_code` / `frame_error` is high for exactly one cycle, the cycle after the rising edge of `s` that ends the stop burst. `ir_data` changes in that same cycle and holds until the next valid frame.
- At most one of the three pulses is high in any cycle.
- A timeout error pulses one cycle after the counter reaches the limit.
- Back-to-back frames: a falling edge arriving in the same cycle as a completion pulse is recorded, and the next frame decodes normally.

## Test plan
- CYC_PER_US=1; NEC frame, address 0x00, command 0x14 (9000/4500 leader, 560 bursts, 560/1690 spaces, 560 stop) -> `data_ready` single pulse, `ir_data` = 0xEB14FF00.
- Valid frame with command 0x0C, then a repeat frame (9000 low / 2250 high / 560 low) -> `data_ready` with `ir_data` = 0xF30CFF00, then `repeat_code` pulse with `ir_data` still 0xF30CFF00.
- Frame with byte 3 = 0x00 and command 0x18 (complement mismatch) -> `frame_error` pulse, no `data_ready`, `ir_data` keeps its previous value.
- Leader burst of 6000 low -> `frame_error` at its rising edge; a following valid 0x1B frame -> `ir_data` = 0xE41BFF00.
- `ir_in` held high after bit 10 -> `frame_error` exactly 11000+1 cycles after the last edge; state returns to IDLE.
- `rst_n` low for 1 cycle during bit 20 of a frame -> all outputs 0, no pulses for that frame; the next valid 0x1F frame -> `ir_data` = 0xE01FFF00.

Source files
------------

// File: rtl/ir_nec_receiver_if.sv
// Demodulated IR input plus the decoded-frame outputs of the NEC receiver.
interface ir_nec_receiver_if;
  logic        ir_in;
  logic [31:0] ir_data;
  logic        data_ready;
  logic        repeat_code;
  logic        frame_error;

  modport master (
    output ir_in,
    input  ir_data, data_ready, repeat_code, frame_error
  );

  modport slave (
    input  ir_in,
    output ir_data, data_ready, repeat_code, frame_error
  );
endinterface

// File: rtl/ir_nec_receiver.sv
// NEC IR frame decoder: pulse-width classification of the synchronized receiver
// output into 32-bit frames, with repeat-code detection and timeout recovery.
module ir_nec_receiver #(
  parameter int CYC_PER_US = 50
) (
  input  logic             clk,
  input  logic             rst_n,
  ir_nec_receiver_if.slave ir
);
  localparam int CW = $clog2(11000 * CYC_PER_US + 1);
  localparam logic [CW-1:0] TIMEOUT = CW'(11000 * CYC_PER_US);

  localparam logic [2:0] IDLE       = 3'd0;
  localparam logic [2:0] LEAD_BURST = 3'd1;
  localparam logic [2:0] LEAD_SPACE = 3'd2;
  localparam logic [2:0] BIT_BURST  = 3'd3;
  localparam logic [2:0] BIT_SPACE  = 3'd4;
  localparam logic [2:0] STOP_BURST = 3'd5;

  logic [2:0]    state, nxt;
  logic          sync1, sync2, s_prev, s, rose, fell;
  logic [CW-1:0] cnt;
  logic [4:0]    idx;
  logic [31:0]   shift;
  logic          rpt;
  logic          err, done, bit_we, bit_val, set_rpt;

  function automatic logic in_win(input logic [CW-1:0] v, input int lo_us, input int hi_us);
    return (v >= CW'(lo_us * CYC_PER_US)) && (v <= CW'(hi_us * CYC_PER_US));
  endfunction

  assign s    = sync2;
  assign rose = s & ~s_prev;
  assign fell = ~s & s_prev;

  always_comb begin
    nxt     = state;
    err     = 1'b0;
    done    = 1'b0;
    bit_we  = 1'b0;
    bit_val = 1'b0;
    set_rpt = 1'b0;
    case (state)
      IDLE:       if (fell) nxt = LEAD_BURST;
      LEAD_BURST: if (rose) begin
                    if (in_win(cnt, 8000, 10000)) nxt = LEAD_SPACE;
                    else                          err = 1'b1;
                  end
      LEAD_SPACE: if (fell) begin
                    if (in_win(cnt, 4000, 5000)) nxt = BIT_BURST;
                    else if (in_win(cnt, 2000, 2500)) begin
                      nxt     = STOP_BURST;
                      set_rpt = 1'b1;
                    end
                    else err = 1'b1;
                  end
      BIT_BURST:  if (rose) begin
                    if (in_win(cnt, 400, 700)) nxt = BIT_SPACE;
                    else                       err = 1'b1;
                  end
      BIT_SPACE:  if (fell) begin
                    if (in_win(cnt, 400, 700)) bit_we = 1'b1;
                    else if (in_win(cnt, 1400, 1900)) begin
                      bit_we  = 1'b1;
                      bit_val = 1'b1;
                    end
                    else err = 1'b1;
                    if (bit_we) nxt = (idx == 5'd31) ? STOP_BURST : BIT_BURST;
                  end
      STOP_BURST: if (rose) begin
                    if (in_win(cnt, 400, 700)) begin
                      done = 1'b1;
                      nxt  = IDLE;
                    end
                    else err = 1'b1;
                  end
      default:    nxt = IDLE;
    endcase
    if (state != IDLE && cnt == TIMEOUT) err = 1'b1;
    // A low line after an error means the edge that caused it may be a new leader.
    if (err) begin
      done    = 1'b0;
      bit_we  = 1'b0;
      set_rpt = 1'b0;
      nxt     = s ? IDLE : LEAD_BURST;
    end
  end

  // Counter reloads to 1 on an edge so that it always equals cycles elapsed
  // since the edge; the old value is still visible for classification in the edge cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1          <= 1'b1;
      sync2          <= 1'b1;
      s_prev         <= 1'b1;
      cnt            <= '0;
      state          <= IDLE;
      idx            <= '0;
      shift          <= '0;
      rpt            <= 1'b0;
      ir.ir_data     <= '0;
      ir.data_ready  <= 1'b0;
      ir.repeat_code <= 1'b0;
      ir.frame_error <= 1'b0;
    end else begin
      sync1  <= ir.ir_in;
      sync2  <= sync1;
      s_prev <= sync2;
      if (rose || fell)  cnt <= CW'(1);
      else if (cnt != '1) cnt <= cnt + CW'(1);
      state <= nxt;
      if (bit_we) begin
        shift[idx] <= bit_val;
        idx        <= idx + 5'd1;
      end
      else if (state == LEAD_SPACE) idx <= '0;
      ir.data_ready  <= 1'b0;
      ir.repeat_code <= 1'b0;
      ir.frame_error <= 1'b0;
      if (err) begin
        ir.frame_error <= 1'b1;
        rpt            <= 1'b0;
      end
      else if (done) begin
        rpt <= 1'b0;
        if (rpt) ir.repeat_code <= 1'b1;
        else if (shift[31:24] == ~shift[23:16]) begin
          ir.ir_data    <= shift;
          ir.data_ready <= 1'b1;
        end
        else ir.frame_error <= 1'b1;
      end
      else if (set_rpt) rpt <= 1'b1;
    end
  end
endmodule

// File: tb/tb_ir_nec_receiver.sv
// Directed NEC-frame bench for ir_nec_receiver at one cycle per microsecond.
module tb_ir_nec_receiver;
  logic clk = 1'b0;
  logic rst_n;

  ir_nec_receiver_if ir_bus ();

  ir_nec_receiver #(.CYC_PER_US(1)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .ir   (ir_bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;
  int dr_cnt = 0;
  int rp_cnt = 0;
  int fe_cnt = 0;
  int multi_cnt = 0;

  // Pulse tallies, sampled mid-cycle.
  always @(negedge clk) begin
    if (ir_bus.data_ready)  dr_cnt++;
    if (ir_bus.repeat_code) rp_cnt++;
    if (ir_bus.frame_error) fe_cnt++;
    if (int'(ir_bus.data_ready) + int'(ir_bus.repeat_code) + int'(ir_bus.frame_error) > 1)
      multi_cnt++;
  end

  function automatic logic [31:0] nec_word(input logic [7:0] cmd);
    return {~cmd, cmd, 8'hFF, 8'h00};
  endfunction

  task automatic hold(input logic lvl, input int n);
    ir_bus.ir_in = lvl;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_leader();
    hold(1'b0, 9000);
    hold(1'b1, 4500);
  endtask

  task automatic send_bits(input logic [31:0] w, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      hold(1'b0, 560);
      hold(1'b1, w[i] ? 1690 : 560);
    end
  endtask

  task automatic send_frame(input logic [31:0] w);
    send_leader();
    send_bits(w, 32);
    hold(1'b0, 560);
    hold(1'b1, 20);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    ir_bus.ir_in = 1'b1;
    repeat (5) @(negedge clk);
    n_cmp++;
    if (ir_bus.ir_data !== 32'h0) begin
      n_fail++; $display("[TB] FAIL reset_ir_data: got %h want 00000000", ir_bus.ir_data);
    end
    n_cmp++;
    if ({ir_bus.data_ready, ir_bus.repeat_code, ir_bus.frame_error} !== 3'b000) begin
      n_fail++; $display("[TB] FAIL reset_pulses: got %b want 000",
                         {ir_bus.data_ready, ir_bus.repeat_code, ir_bus.frame_error});
    end
    rst_n = 1'b1;
    hold(1'b1, 20);
  endtask

  task automatic test_data_frame();
    int dr0, fe0;
    dr0 = dr_cnt; fe0 = fe_cnt;
    send_frame(nec_word(8'h14));
    n_cmp++;
    if (dr_cnt - dr0 !== 1) begin
      n_fail++; $display("[TB] FAIL frame14_ready_cycles: got %0d want 1", dr_cnt - dr0);
    end
    n_cmp++;
    if (ir_bus.ir_data !== 32'hEB14FF00) begin
      n_fail++; $display("[TB] FAIL frame14_data: got %h want EB14FF00", ir_bus.ir_data);
    end
    n_cmp++;
    if (fe_cnt - fe0 !== 0) begin
      n_fail++; $display("[TB] FAIL frame14_errors: got %0d want 0", fe_cnt - fe0);
    end
  endtask

  task automatic test_repeat();
    int dr0, rp0;
    dr0 = dr_cnt; rp0 = rp_cnt;
    send_frame(nec_word(8'h0C));
    n_cmp++;
    if (ir_bus.ir_data !== 32'hF30CFF00) begin
      n_fail++; $display("[TB] FAIL frame0C_data: got %h want F30CFF00", ir_bus.ir_data);
    end
    dr0 = dr_cnt;
    hold(1'b0, 9000);
    hold(1'b1, 2250);
    hold(1'b0, 560);
    hold(1'b1, 20);
    n_cmp++;
    if (rp_cnt - rp0 !== 1) begin
      n_fail++; $display("[TB] FAIL repeat_pulse_cycles: got %0d want 1", rp_cnt - rp0);
    end
    n_cmp++;
    if (dr_cnt - dr0 !== 0) begin
      n_fail++; $display("[TB] FAIL repeat_no_ready: got %0d want 0", dr_cnt - dr0);
    end
    n_cmp++;
    if (ir_bus.ir_data !== 32'hF30CFF00) begin
      n_fail++; $display("[TB] FAIL repeat_data_kept: got %h want F30CFF00", ir_bus.ir_data);
    end
  endtask

  task automatic test_complement_error();
    int dr0, fe0;
    dr0 = dr_cnt; fe0 = fe_cnt;
    send_frame({8'h00, 8'h18, 8'hFF, 8'h00});
    n_cmp++;
    if (fe_cnt - fe0 !== 1) begin
      n_fail++; $display("[TB] FAIL cmpl_error_cycles: got %0d want 1", fe_cnt - fe0);
    end
    n_cmp++;
    if (dr_cnt - dr0 !== 0) begin
      n_fail++; $display("[TB] FAIL cmpl_no_ready: got %0d want 0", dr_cnt - dr0);
    end
    n_cmp++;
    if (ir_bus.ir_data !== 32'hF30CFF00) begin
      n_fail++; $display("[TB] FAIL cmpl_data_kept: got %h want F30CFF00", ir_bus.ir_data);
    end
  endtask

  task automatic test_bad_leader();
    int dr0;
    hold(1'b0, 6000);
    hold(1'b1, 2);
    n_cmp++;
    if (ir_bus.frame_error !== 1'b0) begin
      n_fail++; $display("[TB] FAIL short_leader_early: got %b want 0", ir_bus.frame_error);
    end
    @(negedge clk);
    n_cmp++;
    if (ir_bus.frame_error !== 1'b1) begin
      n_fail++; $display("[TB] FAIL short_leader_pulse: got %b want 1", ir_bus.frame_error);
    end
    @(negedge clk);
    n_cmp++;
    if (ir_bus.frame_error !== 1'b0) begin
      n_fail++; $display("[TB] FAIL short_leader_width: got %b want 0", ir_bus.frame_error);
    end
    hold(1'b1, 100);
    dr0 = dr_cnt;
    send_frame(nec_word(8'h1B));
    n_cmp++;
    if (dr_cnt - dr0 !== 1) begin
      n_fail++; $display("[TB] FAIL frame1B_ready_cycles: got %0d want 1", dr_cnt - dr0);
    end
    n_cmp++;
    if (ir_bus.ir_data !== 32'hE41BFF00) begin
      n_fail++; $display("[TB] FAIL frame1B_data: got %h want E41BFF00", ir_bus.ir_data);
    end
  endtask

  task automatic test_timeout();
    int fe0, dr0;
    fe0 = fe_cnt; dr0 = dr_cnt;
    send_leader();
    send_bits(nec_word(8'h1B), 10);
    hold(1'b0, 560);
    // Synchronizer adds 2 cycles, so the pulse lands 11003 cycles after ir_in rises.
    hold(1'b1, 11002);
    n_cmp++;
    if (ir_bus.frame_error !== 1'b0 || fe_cnt != fe0) begin
      n_fail++; $display("[TB] FAIL timeout_early: got fe=%b count=%0d want fe=0 count=0",
                         ir_bus.frame_error, fe_cnt - fe0);
    end
    @(negedge clk);
    n_cmp++;
    if (ir_bus.frame_error !== 1'b1) begin
      n_fail++; $display("[TB] FAIL timeout_pulse: got %b want 1", ir_bus.frame_error);
    end
    @(negedge clk);
    n_cmp++;
    if (ir_bus.frame_error !== 1'b0) begin
      n_fail++; $display("[TB] FAIL timeout_width: got %b want 0", ir_bus.frame_error);
    end
    hold(1'b1, 50);
    n_cmp++;
    if (fe_cnt - fe0 !== 1 || dr_cnt - dr0 !== 0) begin
      n_fail++; $display("[TB] FAIL timeout_totals: got fe=%0d dr=%0d want fe=1 dr=0",
                         fe_cnt - fe0, dr_cnt - dr0);
    end
    n_cmp++;
    if (ir_bus.ir_data !== 32'hE41BFF00) begin
      n_fail++; $display("[TB] FAIL timeout_data_kept: got %h want E41BFF00", ir_bus.ir_data);
    end
  endtask

  task automatic test_reset_mid_frame();
    int fe0, dr0, rp0;
    fe0 = fe_cnt; dr0 = dr_cnt; rp0 = rp_cnt;
    send_leader();
    send_bits(nec_word(8'h1F), 20);
    hold(1'b0, 560);
    hold(1'b1, 300);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    n_cmp++;
    if (ir_bus.ir_data !== 32'h0) begin
      n_fail++; $display("[TB] FAIL midreset_data: got %h want 00000000", ir_bus.ir_data);
    end
    hold(1'b1, 200);
    n_cmp++;
    if (fe_cnt - fe0 !== 0 || dr_cnt - dr0 !== 0 || rp_cnt - rp0 !== 0) begin
      n_fail++; $display("[TB] FAIL midreset_pulses: got fe=%0d dr=%0d rp=%0d want 0 0 0",
                         fe_cnt - fe0, dr_cnt - dr0, rp_cnt - rp0);
    end
    send_frame(nec_word(8'h1F));
    n_cmp++;
    if (dr_cnt - dr0 !== 1 || fe_cnt - fe0 !== 0) begin
      n_fail++; $display("[TB] FAIL frame1F_pulses: got dr=%0d fe=%0d want dr=1 fe=0",
                         dr_cnt - dr0, fe_cnt - fe0);
    end
    n_cmp++;
    if (ir_bus.ir_data !== 32'hE01FFF00) begin
      n_fail++; $display("[TB] FAIL frame1F_data: got %h want E01FFF00", ir_bus.ir_data);
    end
  endtask

  task automatic test_exclusive_pulses();
    n_cmp++;
    if (multi_cnt !== 0) begin
      n_fail++; $display("[TB] FAIL exclusive_pulses: got %0d overlapping cycles want 0", multi_cnt);
    end
  endtask

  initial begin
    $display("[TB] starting ir_nec_receiver bench");
    test_reset();
    test_data_frame();
    test_repeat();
    test_complement_error();
    test_bad_leader();
    test_timeout();
    test_reset_mid_frame();
    test_exclusive_pulses();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
